reg_file_wb: RTL and testbench
==============================

// Module: reg_file_wb
// PURPOSE
//   Architectural register file: the consumer end of the write-back path.
//   Sits in the decode stage. Accepts regwrite/write_reg/write_data from the
//   write-back data select and serves two combinational read ports, with
//   same-cycle write-to-read bypass.
//   Tracks registers with outstanding multi-cycle loads in a pending scoreboard.
//   Raises stall when decode reads a register whose load has not yet written back.
// PARAMETERS
//   DATA_W    32  register width in bits
//   ADDR_W    5   register index width
//   NUM_REGS  32  number of registers (2**ADDR_W); register 0 is hardwired zero
// PORTS
//   clk          in   1       clock; all state updates on posedge
//   rst          in   1       synchronous, active-high reset
//   regwrite     in   1       write-back enable
//   write_reg    in   ADDR_W  write-back destination index
//   write_data   in   DATA_W  write-back value
//   read_reg1    in   ADDR_W  read port 1 index
//   read_reg2    in   ADDR_W  read port 2 index
//   rd1_en       in   1       port 1 operand is actually used (qualifies stall)
//   rd2_en       in   1       port 2 operand is actually used (qualifies stall)
//   set_pending  in   1       a load targeting pend_reg issues this cycle
//   pend_reg     in   ADDR_W  destination index of the issuing load
//   read_data1   out  DATA_W  port 1 data (combinational)
//   read_data2   out  DATA_W  port 2 data (combinational)
//   stall        out  1       decode must hold: a used operand is pending
//   busy         out  1       OR of all pending bits
// BEHAVIOUR
//   Reset
//     - At a posedge with rst=1, all registers clear to 0 and all pending bits clear.
//     - regwrite and set_pending are ignored in that cycle.
//     - Bypass is disabled while rst=1.
//     - After reset: read_data* = 0, stall = 0, busy = 0.
//     - A reset mid-load drops the pending bit. A later write-back to that register is a normal write.
//   Write
//     - At posedge, if regwrite && write_reg != 0: regs[write_reg] <= write_data.
//     - The write also clears pending[write_reg].
//   Register 0
//     - Always reads 0.
//     - Writes to it are dropped.
//     - set_pending with pend_reg = 0 is dropped; register 0 never stalls.
//   Read and bypass
//     - read_dataN = 0 if read_regN == 0.
//     - Otherwise, if !rst && regwrite && write_reg == read_regN: read_dataN = write_data (same-cycle bypass).
//     - Otherwise read_dataN = regs[read_regN].
//     - Zero cycles latency; no internal read state.
//   Scoreboard (one bit per register)
//     - At posedge, set_pending && pend_reg != 0 sets pending[pend_reg].
//     - Set and clear of the same register in the same cycle: set wins.
//       The newer load is outstanding; the older one has just written back.
//   Stall (combinational)
//     - stall = (rd1_en && hitN(read_reg1)) || (rd2_en && hitN(read_reg2)).
//     - hitN(r) = pending[r] && !(regwrite && write_reg == r).
//       A write-back landing this cycle satisfies the read via bypass.
//     - A set_pending in the current cycle does not affect stall until the next cycle.
//     - stall depends only on current-cycle inputs and the scoreboard; no feedback loop.
//   Widths
//     - Index compares are full ADDR_W bits.
//     - write_data is stored unmodified; no sign or width conversion.
// TESTING
//   1 Reset, then read r5/r31 -> read_data1/2 = 0, stall = 0, busy = 0.
//   2 Write r3 = 0xDEADBEEF and read r3 in the same cycle -> read_data1 = 0xDEADBEEF (bypass).
//     Next cycle with regwrite = 0 -> still 0xDEADBEEF.
//   3 regwrite to r0 with 0x1234, then read r0 -> 0. set_pending on r0 -> busy stays 0.
//   4 set_pending r7; next cycle read r7 with rd1_en = 1 -> stall = 1, busy = 1.
//     With rd1_en = 0 -> stall = 0.
//     Write-back r7 = 0x55 -> stall = 0 that cycle and read_data1 = 0x55; busy = 0 the cycle after.
//   5 set_pending r9 and regwrite r9 = 0xAA in the same cycle -> r9 = 0xAA, pending[r9] = 1.
//     Next-cycle read of r9 with rd2_en = 1 -> stall = 1.
//   6 set_pending r4, then assert rst for one cycle -> busy = 0, r4 reads 0, stall = 0.
//     A subsequent write-back r4 = 0x77 -> r4 = 0x77.

Source files
------------

// File: rtl/reg_file_wb.sv
// Architectural register file on the write-back path: two combinational read
// ports with same-cycle bypass, plus a pending-load scoreboard that drives stall.
module reg_file_wb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              regwrite,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  input  logic              rd1_en,
  input  logic              rd2_en,
  input  logic              set_pending,
  input  logic [ADDR_W-1:0] pend_reg,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic              stall,
  output logic              busy
);

  // Flops rather than block RAM: reads are combinational and reset clears every entry.
  logic [DATA_W-1:0]   regs_reg [NUM_REGS];
  logic [NUM_REGS-1:0] pending_reg;

  logic wr_active;
  assign wr_active = regwrite && (write_reg != '0);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        always_ff @(posedge clk) begin
          regs_reg[gi]    <= '0;
          pending_reg[gi] <= 1'b0;
        end
      end else begin : g_live
        logic wr_hit;
        logic set_hit;
        assign wr_hit  = wr_active && (write_reg == ADDR_W'(gi));
        assign set_hit = set_pending && (pend_reg == ADDR_W'(gi));

        always_ff @(posedge clk) begin
          if (rst) begin
            regs_reg[gi] <= '0;
          end else if (wr_hit) begin
            regs_reg[gi] <= write_data;
          end
        end

        // A new load issuing while the older one writes back leaves the bit set.
        always_ff @(posedge clk) begin
          if (rst) begin
            pending_reg[gi] <= 1'b0;
          end else if (set_hit) begin
            pending_reg[gi] <= 1'b1;
          end else if (wr_hit) begin
            pending_reg[gi] <= 1'b0;
          end
        end
      end
    end
  endgenerate

  logic byp1;
  logic byp2;
  logic hit1;
  logic hit2;

  always_comb begin
    byp1 = regwrite && (write_reg == read_reg1);
    byp2 = regwrite && (write_reg == read_reg2);

    read_data1 = regs_reg[read_reg1];
    if (read_reg1 == '0) begin
      read_data1 = '0;
    end else if (!rst && byp1) begin
      read_data1 = write_data;
    end

    read_data2 = regs_reg[read_reg2];
    if (read_reg2 == '0) begin
      read_data2 = '0;
    end else if (!rst && byp2) begin
      read_data2 = write_data;
    end

    // A write-back landing this cycle satisfies the operand through the bypass.
    hit1  = pending_reg[read_reg1] && !byp1;
    hit2  = pending_reg[read_reg2] && !byp2;
    stall = (rd1_en && hit1) || (rd2_en && hit2);
    busy  = |pending_reg;
  end

endmodule

// File: tb/tb_reg_file_wb.sv
// Scoreboarded bench for reg_file_wb: a driver applies directed then random
// cycles and queues expectations from an array model; a monitor checks on negedge.
module tb_reg_file_wb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          regwrite = 1'b0;
  logic [AW-1:0] write_reg = '0;
  logic [DW-1:0] write_data = '0;
  logic [AW-1:0] read_reg1 = '0;
  logic [AW-1:0] read_reg2 = '0;
  logic          rd1_en = 1'b0;
  logic          rd2_en = 1'b0;
  logic          set_pending = 1'b0;
  logic [AW-1:0] pend_reg = '0;
  logic [DW-1:0] read_data1;
  logic [DW-1:0] read_data2;
  logic          stall;
  logic          busy;

  reg_file_wb #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) dut (
    .clk(clk), .rst(rst), .regwrite(regwrite), .write_reg(write_reg),
    .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .rd1_en(rd1_en), .rd2_en(rd2_en), .set_pending(set_pending),
    .pend_reg(pend_reg), .read_data1(read_data1), .read_data2(read_data2),
    .stall(stall), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [AW-1:0] r1;
    logic [AW-1:0] r2;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    logic        st;
    logic        bz;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: architectural view of registers and outstanding loads.
  logic [DW-1:0] m_regs [NR];
  bit            m_pend [NR];

  int vectors  = 0;
  int miscomp  = 0;
  int issued   = 0;

  function automatic logic [DW-1:0] model_read(logic [AW-1:0] r, logic rs, logic rw,
                                               logic [AW-1:0] wr, logic [DW-1:0] wd);
    if (r == 0) return '0;
    if (!rs && rw && wr == r) return wd;
    return m_regs[r];
  endfunction

  task automatic cycle(input bit chk, input logic rs, input logic rw,
                       input logic [AW-1:0] wr, input logic [DW-1:0] wd,
                       input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                       input logic e1, input logic e2,
                       input logic sp, input logic [AW-1:0] pr);
    exp_t e;
    bit any;
    @(posedge clk);
    #1;
    rst = rs; regwrite = rw; write_reg = wr; write_data = wd;
    read_reg1 = r1; read_reg2 = r2; rd1_en = e1; rd2_en = e2;
    set_pending = sp; pend_reg = pr;
    if (chk) begin
      any = 0;
      for (int i = 0; i < NR; i++) if (m_pend[i]) any = 1;
      e.id = issued;
      e.r1 = r1;
      e.r2 = r2;
      e.d1 = model_read(r1, rs, rw, wr, wd);
      e.d2 = model_read(r2, rs, rw, wr, wd);
      e.st = (e1 && m_pend[r1] && !(rw && wr == r1)) ||
             (e2 && m_pend[r2] && !(rw && wr == r2));
      e.bz = any;
      exp_q.push_back(e);
      issued++;
    end
    // Effect of the coming posedge.
    if (rs) begin
      for (int i = 0; i < NR; i++) begin
        m_regs[i] = '0;
        m_pend[i] = 0;
      end
    end else begin
      if (rw && wr != 0) begin
        m_regs[wr] = wd;
        m_pend[wr] = 0;
      end
      if (sp && pr != 0) m_pend[pr] = 1;
    end
  endtask

  task automatic rd(input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                    input logic e1, input logic e2);
    cycle(1, 0, 0, '0, '0, r1, r2, e1, e2, 0, '0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors++;
      if (read_data1 !== e.d1 || read_data2 !== e.d2 || stall !== e.st || busy !== e.bz) begin
        miscomp++;
        $display("FAIL txn%0d r%0d/r%0d: rd1=%h rd2=%h stall=%b busy=%b, required rd1=%h rd2=%h stall=%b busy=%b",
                 e.id, e.r1, e.r2, read_data1, read_data2, stall, busy, e.d1, e.d2, e.st, e.bz);
      end else begin
        $display("ok   txn%0d r%0d/r%0d: rd1=%h rd2=%h stall=%b busy=%b",
                 e.id, e.r1, e.r2, read_data1, read_data2, stall, busy);
      end
    end
  end

  initial begin
    int waited;
    logic [AW-1:0] a1, a2, wr, pr;
    for (int i = 0; i < NR; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 0;
    end

    // Power-on state is unknown until the first reset edge.
    cycle(0, 1, 0, '0, '0, 5'd5, 5'd31, 0, 0, 0, '0);
    rd(5'd5, 5'd31, 1, 1);

    cycle(1, 0, 1, 5'd3, 32'hDEADBEEF, 5'd3, 5'd0, 1, 0, 0, '0);
    rd(5'd3, 5'd3, 1, 1);

    cycle(1, 0, 1, 5'd0, 32'h1234, 5'd0, 5'd3, 1, 1, 0, '0);
    rd(5'd0, 5'd0, 1, 1);
    cycle(1, 0, 0, '0, '0, 5'd0, 5'd0, 1, 1, 1, 5'd0);
    rd(5'd0, 5'd3, 1, 1);

    cycle(1, 0, 0, '0, '0, 5'd1, 5'd2, 0, 0, 1, 5'd7);
    rd(5'd7, 5'd0, 1, 0);
    rd(5'd7, 5'd0, 0, 0);
    cycle(1, 0, 1, 5'd7, 32'h55, 5'd7, 5'd7, 1, 1, 0, '0);
    rd(5'd7, 5'd0, 1, 0);

    cycle(1, 0, 1, 5'd9, 32'hAA, 5'd1, 5'd2, 0, 0, 1, 5'd9);
    rd(5'd0, 5'd9, 0, 1);
    cycle(1, 0, 1, 5'd9, 32'hBB, 5'd9, 5'd9, 1, 1, 0, '0);

    cycle(1, 0, 0, '0, '0, 5'd4, 5'd4, 1, 1, 1, 5'd4);
    cycle(1, 1, 1, 5'd4, 32'h99, 5'd4, 5'd3, 1, 1, 1, 5'd5);
    rd(5'd4, 5'd3, 1, 1);
    cycle(1, 0, 1, 5'd4, 32'h77, 5'd1, 5'd1, 0, 0, 0, '0);
    rd(5'd4, 5'd4, 1, 1);

    // Random traffic over a small index window so hits and collisions are frequent.
    for (int n = 0; n < 600; n++) begin
      a1 = AW'($urandom_range(0, 7));
      a2 = AW'($urandom_range(0, 7));
      wr = AW'($urandom_range(0, 7));
      pr = AW'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) a1 = AW'($urandom);
      if ($urandom_range(0, 9) == 0) wr = AW'($urandom);
      cycle(1, ($urandom_range(0, 49) == 0), ($urandom_range(0, 2) == 0), wr, $urandom,
            a1, a2, $urandom_range(0, 1), $urandom_range(0, 1),
            ($urandom_range(0, 3) == 0), pr);
    end
    cycle(0, 0, 0, '0, '0, '0, '0, 0, 0, 0, '0);

    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    if (exp_q.size() > 0 || vectors != issued) begin
      miscomp++;
      $display("FAIL drain: checked %0d, required %0d", vectors, issued);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomp);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: checked %0d, required %0d", vectors, issued);
    $fatal(1, "timeout");
  end

endmodule
